// File: rtl/agendador_medidas_dht11.sv
// Measurement scheduler for the DHT11 interface: periodic/on-demand start pulses,
// watchdog supervision, retry with back-off, and holding of the last good reading.
module agendador_medidas_dht11 #(
    parameter int PERIODO_CICLOS    = 100_000_000,
    parameter int TIMEOUT_CICLOS    = 5_000_000,
    parameter int INTERVALO_RETENTA = 50_000_000,
    parameter int MAX_FALHAS        = 3
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        habilita_i,
    input  logic        pedir_medida_i,
    input  logic        pronto_medida_i,
    input  logic        erro_i,
    input  logic [15:0] temperatura_in_i,
    input  logic [15:0] umidade_in_i,
    output logic        medir_dht11_o,
    output logic [15:0] temperatura_o,
    output logic [15:0] umidade_o,
    output logic        medida_valida_o,
    output logic        nova_medida_o,
    output logic        falha_sensor_o,
    output logic [3:0]  contagem_falhas_o,
    output logic [3:0]  db_estado_o
);
    localparam int MAX_AB = (PERIODO_CICLOS > TIMEOUT_CICLOS) ? PERIODO_CICLOS : TIMEOUT_CICLOS;
    localparam int MAXP   = (MAX_AB > INTERVALO_RETENTA) ? MAX_AB : INTERVALO_RETENTA;
    localparam int TW     = (MAXP > 2) ? $clog2(MAXP) : 1;

    localparam logic [TW-1:0] PER_LIM = TW'(PERIODO_CICLOS - 1);
    localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] RET_LIM = TW'(INTERVALO_RETENTA - 1);
    localparam logic [3:0]    MAX_F   = 4'(MAX_FALHAS);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        DISPARA  = 4'd2,
        AGUARDA  = 4'd3,
        ARMAZENA = 4'd4,
        FALHA    = 4'd5,
        RECUPERA = 4'd6
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          pend_q, pend_d;
    logic [15:0]   temp_q, temp_d, umid_q, umid_d;
    logic          valida_q, valida_d;
    logic          falha_q, falha_d;
    logic [3:0]    cont_q, cont_d;
    logic [3:0]    cont_inc;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            estado_q <= INICIAL;
            timer_q  <= '0;
            wdog_q   <= '0;
            pend_q   <= 1'b0;
            temp_q   <= '0;
            umid_q   <= '0;
            valida_q <= 1'b0;
            falha_q  <= 1'b0;
            cont_q   <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            wdog_q   <= wdog_d;
            pend_q   <= pend_d;
            temp_q   <= temp_d;
            umid_q   <= umid_d;
            valida_q <= valida_d;
            falha_q  <= falha_d;
            cont_q   <= cont_d;
        end
    end

    assign cont_inc = (cont_q >= MAX_F) ? MAX_F : cont_q + 4'd1;

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        wdog_d   = wdog_q;
        pend_d   = pend_q;
        temp_d   = temp_q;
        umid_d   = umid_q;
        valida_d = valida_q;
        falha_d  = falha_q;
        cont_d   = cont_q;

        // Requests arriving while busy are remembered and served from ESPERA.
        if (pedir_medida_i && estado_q != ESPERA && estado_q != INICIAL)
            pend_d = 1'b1;

        case (estado_q)
            INICIAL: begin
                timer_d  = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (habilita_i) begin
                    if (timer_q != PER_LIM) timer_d = timer_q + 1'b1;
                end else begin
                    timer_d = '0;
                end
                if (timer_q == PER_LIM || pedir_medida_i || pend_q) begin
                    pend_d   = 1'b0;
                    timer_d  = '0;
                    estado_d = DISPARA;
                end
            end
            DISPARA: begin
                pend_d   = pedir_medida_i;
                wdog_d   = '0;
                estado_d = AGUARDA;
            end
            AGUARDA: begin
                if (wdog_q != TO_LIM) wdog_d = wdog_q + 1'b1;
                if (erro_i) begin
                    estado_d = FALHA;
                end else if (pronto_medida_i) begin
                    temp_d   = temperatura_in_i;
                    umid_d   = umidade_in_i;
                    estado_d = ARMAZENA;
                end else if (wdog_q == TO_LIM) begin
                    estado_d = FALHA;
                end
            end
            ARMAZENA: begin
                valida_d = 1'b1;
                cont_d   = '0;
                falha_d  = 1'b0;
                timer_d  = '0;
                estado_d = ESPERA;
            end
            FALHA: begin
                cont_d  = cont_inc;
                timer_d = '0;
                if (cont_inc == MAX_F) begin
                    falha_d  = 1'b1;
                    valida_d = 1'b0;
                    estado_d = ESPERA;
                end else begin
                    estado_d = RECUPERA;
                end
            end
            RECUPERA: begin
                // Back-off ignores habilita so a started retry sequence always completes.
                if (timer_q == RET_LIM) begin
                    timer_d  = '0;
                    estado_d = DISPARA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: estado_d = INICIAL;
        endcase
    end

    assign medir_dht11_o     = (estado_q == DISPARA);
    assign nova_medida_o     = (estado_q == ARMAZENA);
    assign temperatura_o     = temp_q;
    assign umidade_o         = umid_q;
    assign medida_valida_o   = valida_q;
    assign falha_sensor_o    = falha_q;
    assign contagem_falhas_o = cont_q;
    assign db_estado_o       = estado_q;
endmodule

// File: tb/tb_agendador_medidas_dht11.sv
// Directed bench for the DHT11 scheduler with short timing parameters.
module tb_agendador_medidas_dht11;
    logic        clk = 1'b0;
    logic        rst_n, hab, pedir, pronto, erro;
    logic [15:0] t_in, u_in;
    logic        medir, nova, valida, falha;
    logic [15:0] temp, umid;
    logic [3:0]  cont, est;

    int tests = 0;
    int fails = 0;

    agendador_medidas_dht11 #(
        .PERIODO_CICLOS(20), .TIMEOUT_CICLOS(10), .INTERVALO_RETENTA(5), .MAX_FALHAS(2)
    ) dut (
        .clock_i(clk), .reset_i(rst_n), .habilita_i(hab), .pedir_medida_i(pedir),
        .pronto_medida_i(pronto), .erro_i(erro), .temperatura_in_i(t_in), .umidade_in_i(u_in),
        .medir_dht11_o(medir), .temperatura_o(temp), .umidade_o(umid), .medida_valida_o(valida),
        .nova_medida_o(nova), .falha_sensor_o(falha), .contagem_falhas_o(cont), .db_estado_o(est)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive observations of state s (current one included), bounded.
    task automatic count_state(input logic [3:0] s, output int n);
        n = 0;
        while (est == s && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 0; hab = 0; pedir = 0; pronto = 0; erro = 0; t_in = '0; u_in = '0;
        tick(); tick();
        tests++;
        if ({medir, nova, valida, falha, temp, umid, cont, est} !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0",
                              {medir, nova, valida, falha, temp, umid, cont, est});
        end
    endtask

    task automatic test_periodic();
        int n; bit dirty;
        rst_n = 1; hab = 1;
        tick();
        tests++;
        if (est !== 4'd1) begin fails++; $display("FAIL inicial_one_cycle: est=%0d want 1", est); end
        n = 0; dirty = 0;
        while (est == 4'd1 && n < 200) begin
            if ({medir, nova, valida, falha, temp, umid, cont} !== '0) dirty = 1;
            n++;
            tick();
        end
        tests++;
        if (n != 20) begin fails++; $display("FAIL espera_len: got %0d want 20", n); end
        tests++;
        if (dirty) begin fails++; $display("FAIL outputs_before_pulse: got nonzero want 0"); end
        tests++;
        if (est !== 4'd2 || medir !== 1'b1) begin
            fails++; $display("FAIL first_pulse: est=%0d medir=%b want 2/1", est, medir);
        end
        tick();
        tests++;
        if (est !== 4'd3 || medir !== 1'b0) begin
            fails++; $display("FAIL pulse_width: est=%0d medir=%b want 3/0", est, medir);
        end
    endtask

    task automatic test_store();
        pronto = 1; t_in = 16'h1A05; u_in = 16'h3C00;
        tick();
        pronto = 0;
        tests++;
        if (est !== 4'd4 || nova !== 1'b1 || temp !== 16'h1A05 || umid !== 16'h3C00) begin
            fails++; $display("FAIL store_load: est=%0d nova=%b t=%h u=%h want 4/1/1a05/3c00",
                              est, nova, temp, umid);
        end
        tick();
        tests++;
        if (est !== 4'd1 || nova !== 1'b0 || valida !== 1'b1) begin
            fails++; $display("FAIL store_exit: est=%0d nova=%b valida=%b want 1/0/1", est, nova, valida);
        end
    endtask

    task automatic test_retry_fail();
        int n;
        pedir = 1; tick(); pedir = 0;
        tick();
        erro = 1; tick(); erro = 0;
        tests++;
        if (est !== 4'd5) begin fails++; $display("FAIL erro_to_falha: est=%0d want 5", est); end
        tick();
        tests++;
        if (est !== 4'd6 || cont !== 4'd1 || falha !== 1'b0) begin
            fails++; $display("FAIL first_fail: est=%0d cont=%0d falha=%b want 6/1/0", est, cont, falha);
        end
        count_state(4'd6, n);
        tests++;
        if (n != 5 || est !== 4'd2 || medir !== 1'b1) begin
            fails++; $display("FAIL recupera_len: n=%0d est=%0d medir=%b want 5/2/1", n, est, medir);
        end
        tick();
        erro = 1; tick(); erro = 0;
        tick();
        tests++;
        if (est !== 4'd1 || falha !== 1'b1 || valida !== 1'b0 || cont !== 4'd2 ||
            temp !== 16'h1A05 || umid !== 16'h3C00) begin
            fails++; $display("FAIL second_fail: est=%0d falha=%b valida=%b cont=%0d t=%h u=%h want 1/1/0/2/1a05/3c00",
                              est, falha, valida, cont, temp, umid);
        end
    endtask

    task automatic test_timeout();
        int n;
        pedir = 1; tick(); pedir = 0; tick();
        pronto = 1; t_in = 16'h1B06; u_in = 16'h3D01; tick(); pronto = 0; tick();
        tests++;
        if (falha !== 1'b0 || cont !== 4'd0 || valida !== 1'b1 || temp !== 16'h1B06) begin
            fails++; $display("FAIL success_clears_falha: falha=%b cont=%0d valida=%b t=%h want 0/0/1/1b06",
                              falha, cont, valida, temp);
        end
        pedir = 1; tick(); pedir = 0; tick();
        count_state(4'd3, n);
        tests++;
        if (n != 10 || est !== 4'd5) begin
            fails++; $display("FAIL timeout_len: n=%0d est=%0d want 10/5", n, est);
        end
        tick();
        tests++;
        if (cont !== 4'd1 || est !== 4'd6) begin
            fails++; $display("FAIL timeout_count: cont=%0d est=%0d want 1/6", cont, est);
        end
        count_state(4'd6, n);
        tick();
        pronto = 1; t_in = 16'h1C07; u_in = 16'h3E02; tick(); pronto = 0; tick();
        tests++;
        if (cont !== 4'd0 || temp !== 16'h1C07 || umid !== 16'h3E02 || est !== 4'd1) begin
            fails++; $display("FAIL retry_success: cont=%0d t=%h u=%h est=%0d want 0/1c07/3e02/1",
                              cont, temp, umid, est);
        end
    endtask

    task automatic test_pending();
        int pulses;
        hab = 0;
        pedir = 1; tick(); pedir = 0; tick();
        pedir = 1; tick(); pedir = 0;
        pronto = 1; tick(); pronto = 0;
        tick();
        tests++;
        if (est !== 4'd1) begin fails++; $display("FAIL pend_espera: est=%0d want 1", est); end
        tick();
        tests++;
        if (est !== 4'd2 || medir !== 1'b1) begin
            fails++; $display("FAIL pend_pulse: est=%0d medir=%b want 2/1", est, medir);
        end
        tick();
        pronto = 1; tick(); pronto = 0; tick();
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (medir) pulses++;
            tick();
        end
        tests++;
        if (pulses != 0 || est !== 4'd1) begin
            fails++; $display("FAIL pend_single: pulses=%0d est=%0d want 0/1", pulses, est);
        end
    endtask

    task automatic test_reset_mid();
        pedir = 1; tick(); pedir = 0; tick();
        tests++;
        if (est !== 4'd3) begin fails++; $display("FAIL reach_aguarda: est=%0d want 3", est); end
        pronto = 1; t_in = 16'hFFFF; u_in = 16'hEEEE; rst_n = 0;
        tick();
        pronto = 0; rst_n = 1;
        tests++;
        if ({medir, nova, valida, falha, temp, umid, cont, est} !== '0) begin
            fails++; $display("FAIL reset_mid: got %h want 0",
                              {medir, nova, valida, falha, temp, umid, cont, est});
        end
        tick();
        tests++;
        if (est !== 4'd1 || temp !== 16'h0000 || medir !== 1'b0) begin
            fails++; $display("FAIL after_reset_mid: est=%0d t=%h medir=%b want 1/0/0", est, temp, medir);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_store();
        test_retry_fail();
        test_timeout();
        test_pending();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
